step_pulse_out: RTL and testbench
=================================

// Module: step_pulse_out
// PURPOSE
//   Downstream of step_gen: consumes the commanded step position (cur_step_pos) and drives
//   the STEP/DIR pins of the external stepper driver. Tracks actual position, emits one
//   STEP pulse per unit of position error with guaranteed pulse width, low time and DIR
//   setup time. Retargets on the fly; never truncates a pulse in flight.
// PARAMETERS
//   POS_W          32  position width, two's-complement signed
//   STEP_HIGH_CYC   4  clk cycles STEP held high per pulse (>=1)
//   STEP_LOW_CYC    4  min clk cycles STEP held low after each pulse (>=1)
//   DIR_SETUP_CYC   2  clk cycles DIR stable before STEP rises after a DIR change (>=1)
// PORTS
//   clk        in   1      system clock; all logic on posedge
//   rst        in   1      synchronous, active-high reset
//   tgt_valid  in   1      tgt_pos valid this cycle
//   tgt_ready  out  1      target accepted when tgt_valid & tgt_ready
//   tgt_pos    in   POS_W  commanded absolute step position (signed)
//   enable     in   1      1 = may start new pulses
//   step       out  1      STEP pin, registered
//   dir        out  1      DIR pin, registered; 1 = increment position
//   cur_pos    out  POS_W  actual position (pulses issued), signed
//   busy       out  1      state != IDLE
//   at_target  out  1      state == IDLE and cur_pos == captured target
// BEHAVIOUR
//   - Reset: step=0, dir=0, cur_pos=0, tgt_reg=0, busy=0, at_target=0 during reset cycle
//     (combinational from registers thereafter), tgt_ready=0 while rst, else 1.
//   - Capture: tgt_reg <= tgt_pos on valid&ready in any state; latest write wins.
//   - FSM IDLE/DIR_SETUP/STEP_HIGH/STEP_LOW; one down-counter shared by timed states.
//   - IDLE: if enable & tgt_reg != cur_pos: want = (tgt_reg > cur_pos), signed compare.
//     want != dir -> dir<=want, cnt<=DIR_SETUP_CYC-1, go DIR_SETUP.
//     want == dir -> step<=1, cnt<=STEP_HIGH_CYC-1, go STEP_HIGH (step high next cycle).
//   - DIR_SETUP: cnt==0 -> step<=1, load STEP_HIGH_CYC-1, go STEP_HIGH; else cnt--.
//   - STEP_HIGH: cnt==0 -> step<=0, cur_pos<=cur_pos+/-1 per dir, load STEP_LOW_CYC-1,
//     go STEP_LOW; else cnt--. cur_pos changes same edge STEP falls.
//   - STEP_LOW: cnt==0 -> IDLE; else cnt--. IDLE re-evaluates the following cycle.
//   - Timing: same-dir pulse period = STEP_HIGH_CYC+STEP_LOW_CYC+1 cycles; a DIR change
//     adds DIR_SETUP_CYC. DIR changes only on IDLE exit; stable through setup+pulse+low.
//   - Retarget mid-pulse: pulse and low time complete; direction decided in next IDLE.
//   - Target crossed/reversed: at most the in-flight pulse overshoots by 1, then reverses.
//   - enable=0 mid-move: in-flight pulse/low completes, FSM parks in IDLE; tgt still captured.
//   - rst mid-pulse: step falls on that edge, all state cleared; no partial count.
//   - No wrap handling: cur_pos +/-1 is modular two's complement; POS_W sized by user.
//   - tgt_valid with tgt_pos == cur_pos in IDLE: no pulse, at_target=1 next cycle.
// CONFIGURATION
//   STEP_POS_LIMIT_EN defined: adds ports pos_min/pos_max (in, POS_W, signed) and
//     limit_hit (out, 1, reset 0). Captured target clamped to [pos_min,pos_max];
//     limit_hit set when a capture was clamped, cleared by next unclamped capture.
//     pos_min > pos_max: target clamped to pos_min.
//   Undefined: no extra ports; tgt_reg = tgt_pos unmodified.
// TESTING (defaults HIGH=4 LOW=4 SETUP=2)
//   1 rst held 3 cycles, tgt_valid=1 -> step=0 dir=0 cur_pos=0 busy=0 tgt_ready=0 throughout.
//   2 from 0, enable=1, tgt=3 -> dir=1, 2-cycle setup, 3 pulses 4 high/period 9,
//     cur_pos=3, at_target=1 after last low time.
//   3 from 3, tgt=-2 -> dir falls >=2 cycles before first STEP rise, 5 pulses, cur_pos=-2.
//   4 from 0 tgt=10; write tgt=0 while 2nd pulse high -> pulse completes, cur_pos=2,
//     dir reverses with setup, 2 pulses, cur_pos=0, never >2.
//   5 tgt=5, drop enable during 1st pulse high -> exactly 1 pulse, full width, cur_pos=1,
//     busy=0; re-enable -> 4 more pulses.
//   6 STEP_POS_LIMIT_EN, pos_min=-4 pos_max=4, tgt=100 -> limit_hit=1, cur_pos stops at 4;
//     tgt=2 -> limit_hit=0, 2 down-pulses.

Source files
------------

// File: rtl/step_pulse_out_if.sv
// Target handshake bundle for step_pulse_out: commanded position with valid/ready.
interface step_pulse_out_if #(
  parameter int unsigned POS_W = 32
);
  logic                    tgt_valid;
  logic                    tgt_ready;
  logic signed [POS_W-1:0] tgt_pos;

  modport master (output tgt_valid, output tgt_pos, input tgt_ready);
  modport slave  (input tgt_valid, input tgt_pos, output tgt_ready);
endinterface

// File: rtl/step_pulse_out.sv
// STEP/DIR pin driver: issues one timed STEP pulse per unit of position error toward the target.
// Optional STEP_POS_LIMIT_EN adds pos_min/pos_max target clamping with a limit_hit flag.
module step_pulse_out #(
  parameter int unsigned POS_W         = 32,
  parameter int unsigned STEP_HIGH_CYC = 4,
  parameter int unsigned STEP_LOW_CYC  = 4,
  parameter int unsigned DIR_SETUP_CYC = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  step_pulse_out_if.slave         tgt,
  input  logic                    enable,
  output logic                    step,
  output logic                    dir,
  output logic signed [POS_W-1:0] cur_pos,
  output logic                    busy,
  output logic                    at_target
`ifdef STEP_POS_LIMIT_EN
  ,
  input  logic signed [POS_W-1:0] pos_min,
  input  logic signed [POS_W-1:0] pos_max,
  output logic                    limit_hit
`endif
);

  localparam int unsigned MAX_HL = (STEP_HIGH_CYC > STEP_LOW_CYC) ? STEP_HIGH_CYC : STEP_LOW_CYC;
  localparam int unsigned MAXC   = (MAX_HL > DIR_SETUP_CYC) ? MAX_HL : DIR_SETUP_CYC;
  localparam int unsigned CNT_W  = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CNT_W-1:0] HIGH_LOAD  = CNT_W'(STEP_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] LOW_LOAD   = CNT_W'(STEP_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(DIR_SETUP_CYC - 1);
  localparam logic [POS_W-1:0] ONE        = POS_W'(1);

  typedef enum logic [1:0] {IDLE, DIR_SETUP, STEP_HIGH, STEP_LOW} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic                    step_nxt, dir_nxt;
  logic signed [POS_W-1:0] pos_nxt;
  logic signed [POS_W-1:0] tgt_reg, tgt_in;
  logic                    tgt_clamped;
  logic                    want_up;

`ifdef STEP_POS_LIMIT_EN
  // An inverted window collapses onto pos_min.
  always_comb begin
    tgt_in = tgt.tgt_pos;
    if (pos_min > pos_max)
      tgt_in = pos_min;
    else if (tgt.tgt_pos < pos_min)
      tgt_in = pos_min;
    else if (tgt.tgt_pos > pos_max)
      tgt_in = pos_max;
    tgt_clamped = (tgt_in != tgt.tgt_pos);
  end

  always_ff @(posedge clk) begin
    if (rst)
      limit_hit <= 1'b0;
    else if (tgt.tgt_valid)
      limit_hit <= tgt_clamped;
  end
`else
  always_comb begin
    tgt_in      = tgt.tgt_pos;
    tgt_clamped = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst)
      tgt_reg <= '0;
    else if (tgt.tgt_valid)
      tgt_reg <= tgt_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      step    <= 1'b0;
      dir     <= 1'b0;
      cur_pos <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      step    <= step_nxt;
      dir     <= dir_nxt;
      cur_pos <= pos_nxt;
    end
  end

  assign want_up = (tgt_reg > cur_pos);

  // Next-state logic also carries the registered pin and position updates so each
  // pin edge lines up with its state transition.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    step_nxt  = step;
    dir_nxt   = dir;
    pos_nxt   = cur_pos;
    unique case (state)
      IDLE: begin
        if (enable && (tgt_reg != cur_pos)) begin
          if (want_up != dir) begin
            dir_nxt   = want_up;
            cnt_nxt   = SETUP_LOAD;
            state_nxt = DIR_SETUP;
          end else begin
            step_nxt  = 1'b1;
            cnt_nxt   = HIGH_LOAD;
            state_nxt = STEP_HIGH;
          end
        end
      end
      DIR_SETUP: begin
        if (cnt == '0) begin
          step_nxt  = 1'b1;
          cnt_nxt   = HIGH_LOAD;
          state_nxt = STEP_HIGH;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      STEP_HIGH: begin
        if (cnt == '0) begin
          step_nxt  = 1'b0;
          pos_nxt   = dir ? (cur_pos + ONE) : (cur_pos - ONE);
          cnt_nxt   = LOW_LOAD;
          state_nxt = STEP_LOW;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      STEP_LOW: begin
        if (cnt == '0)
          state_nxt = IDLE;
        else
          cnt_nxt = cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tgt.tgt_ready = !rst;
    busy          = !rst && (state != IDLE);
    at_target     = !rst && (state == IDLE) && (cur_pos == tgt_reg);
  end

endmodule

// File: tb/tb_step_pulse_out.sv
// Bench for step_pulse_out: event-schedule reference model plus directed and random scenarios.
// Define STEP_POS_LIMIT_EN to exercise target clamping as well.
module tb_step_pulse_out;
  localparam int H = 4;
  localparam int L = 4;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic step, dir, busy, at_target;
  logic signed [31:0] cur_pos;
  logic limit_hit;

  step_pulse_out_if #(.POS_W(32)) tif ();

`ifdef STEP_POS_LIMIT_EN
  logic signed [31:0] pos_min, pos_max;
`else
  assign limit_hit = 1'b0;
`endif

  step_pulse_out #(
    .POS_W(32), .STEP_HIGH_CYC(H), .STEP_LOW_CYC(L), .DIR_SETUP_CYC(S)
  ) dut (
    .clk(clk), .rst(rst), .tgt(tif), .enable(enable),
    .step(step), .dir(dir), .cur_pos(cur_pos), .busy(busy), .at_target(at_target)
`ifdef STEP_POS_LIMIT_EN
    , .pos_min(pos_min), .pos_max(pos_max), .limit_hit(limit_hit)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: each move is a scheduled triple of edges (rise, fall, end).
  int e_n = 0;
  bit m_act = 0;
  int rise_e, fall_e, end_e;
  logic signed [31:0] m_pos = 0, m_tgt = 0;
  logic m_dir = 0, m_step = 0, m_lim = 0;
  logic e_busy, e_at, e_rdy;

  task automatic tick();
    logic signed [31:0] v;
    @(posedge clk);
    e_n++;
    if (rst) begin
      m_act = 0; m_pos = 0; m_tgt = 0; m_dir = 0; m_step = 0; m_lim = 0;
    end else begin
      if (!m_act) begin
        if (enable && m_tgt != m_pos) begin
          m_act  = 1;
          rise_e = e_n;
          if ((m_tgt > m_pos) != m_dir) begin
            m_dir  = !m_dir;
            rise_e = e_n + S;
          end
          fall_e = rise_e + H;
          end_e  = fall_e + L;
          if (rise_e == e_n) m_step = 1;
        end
      end else begin
        if (e_n == rise_e) m_step = 1;
        if (e_n == fall_e) begin
          m_step = 0;
          m_pos  = m_dir ? m_pos + 1 : m_pos - 1;
        end
        if (e_n == end_e) m_act = 0;
      end
      if (tif.tgt_valid) begin
        v = tif.tgt_pos;
`ifdef STEP_POS_LIMIT_EN
        if (pos_min > pos_max) v = pos_min;
        else if (v < pos_min) v = pos_min;
        else if (v > pos_max) v = pos_max;
        m_lim = (v != tif.tgt_pos);
`endif
        m_tgt = v;
      end
    end
    #1;
    e_rdy  = !rst;
    e_busy = !rst && m_act;
    e_at   = !rst && !m_act && (m_pos == m_tgt);
  endtask

  task automatic test_reset();
    rst = 1; enable = 1; tif.tgt_valid = 1;
    for (int i = 0; i < 3; i++) begin
      tif.tgt_pos = $urandom;
      tick();
      total++;
      if ({step, dir, busy, at_target, tif.tgt_ready, limit_hit} !== {m_step, m_dir, e_busy, e_at, e_rdy, m_lim} || cur_pos !== m_pos) begin
        bad++;
        $display("FAIL reset_model @%0d: got sdbarl=%b%b%b%b%b%b pos=%0d want %b%b%b%b%b%b pos=%0d", e_n,
                 step, dir, busy, at_target, tif.tgt_ready, limit_hit, cur_pos, m_step, m_dir, e_busy, e_at, e_rdy, m_lim, m_pos);
      end
      total++;
      if ({step, dir, busy, at_target, tif.tgt_ready} !== 5'b0 || cur_pos !== 0) begin
        bad++;
        $display("FAIL reset_state: got sdbar=%b%b%b%b%b pos=%0d want 00000 pos=0", step, dir, busy, at_target, tif.tgt_ready, cur_pos);
      end
    end
    rst = 0; tif.tgt_valid = 0;
  endtask

  task automatic test_move_up();
    int rises = 0, run = 0, last_rise = -1;
    logic prev = 0;
    bit done = 0;
    tif.tgt_valid = 1; tif.tgt_pos = 3; enable = 1;
    for (int i = 0; i < 200; i++) begin
      tick();
      tif.tgt_valid = 0;
      total++;
      if ({step, dir, busy, at_target, tif.tgt_ready, limit_hit} !== {m_step, m_dir, e_busy, e_at, e_rdy, m_lim} || cur_pos !== m_pos) begin
        bad++;
        $display("FAIL move_up @%0d: got sdbarl=%b%b%b%b%b%b pos=%0d want %b%b%b%b%b%b pos=%0d", e_n,
                 step, dir, busy, at_target, tif.tgt_ready, limit_hit, cur_pos, m_step, m_dir, e_busy, e_at, e_rdy, m_lim, m_pos);
      end
      if (step && !prev) begin
        rises++;
        if (last_rise >= 0) begin
          total++;
          if (e_n - last_rise != H + L + 1) begin
            bad++;
            $display("FAIL move_up_period: got %0d want %0d", e_n - last_rise, H + L + 1);
          end
        end
        last_rise = e_n;
      end
      if (step) run++;
      if (!step && prev) begin
        total++;
        if (run != H) begin
          bad++;
          $display("FAIL move_up_width: got %0d want %0d", run, H);
        end
        run = 0;
      end
      prev = step;
      if (i > 0 && !m_act && m_pos == m_tgt) begin done = 1; break; end
    end
    total++;
    if (!done || cur_pos !== 3 || at_target !== 1'b1 || dir !== 1'b1 || rises != 3) begin
      bad++;
      $display("FAIL move_up_end: got done=%0d pos=%0d at=%b dir=%b rises=%0d want done=1 pos=3 at=1 dir=1 rises=3",
               done, cur_pos, at_target, dir, rises);
    end
    tif.tgt_valid = 1; tif.tgt_pos = 3;
    tick();
    tif.tgt_valid = 0;
    tick();
    total++;
    if (busy !== 1'b0 || at_target !== 1'b1 || cur_pos !== 3) begin
      bad++;
      $display("FAIL same_target: got busy=%b at=%b pos=%0d want busy=0 at=1 pos=3", busy, at_target, cur_pos);
    end
  endtask

  task automatic test_reverse();
    int rises = 0, dir_e = -1, first_rise = -1;
    logic prev_s = 0, prev_d = 1;
    bit done = 0;
    tif.tgt_valid = 1; tif.tgt_pos = -2;
    for (int i = 0; i < 200; i++) begin
      tick();
      tif.tgt_valid = 0;
      total++;
      if ({step, dir, busy, at_target, tif.tgt_ready, limit_hit} !== {m_step, m_dir, e_busy, e_at, e_rdy, m_lim} || cur_pos !== m_pos) begin
        bad++;
        $display("FAIL reverse @%0d: got sdbarl=%b%b%b%b%b%b pos=%0d want %b%b%b%b%b%b pos=%0d", e_n,
                 step, dir, busy, at_target, tif.tgt_ready, limit_hit, cur_pos, m_step, m_dir, e_busy, e_at, e_rdy, m_lim, m_pos);
      end
      if (!dir && prev_d && dir_e < 0) dir_e = e_n;
      if (step && !prev_s) begin
        rises++;
        if (first_rise < 0) first_rise = e_n;
      end
      prev_s = step; prev_d = dir;
      if (i > 0 && !m_act && m_pos == m_tgt) begin done = 1; break; end
    end
    total++;
    if (!done || cur_pos !== -2 || rises != 5 || dir_e < 0 || first_rise - dir_e < S) begin
      bad++;
      $display("FAIL reverse_end: got done=%0d pos=%0d rises=%0d setup=%0d want done=1 pos=-2 rises=5 setup>=%0d",
               done, cur_pos, rises, first_rise - dir_e, S);
    end
  endtask

  task automatic test_retarget();
    int rises = 0;
    logic prev = 0;
    logic signed [31:0] maxp = -100;
    bit done = 0, hit = 0;
    tif.tgt_valid = 1; tif.tgt_pos = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      tif.tgt_valid = 0;
      if (i > 0 && !m_act && m_pos == m_tgt) break;
    end
    tif.tgt_valid = 1; tif.tgt_pos = 10;
    for (int i = 0; i < 300; i++) begin
      tick();
      tif.tgt_valid = 0;
      total++;
      if ({step, dir, busy, at_target, tif.tgt_ready, limit_hit} !== {m_step, m_dir, e_busy, e_at, e_rdy, m_lim} || cur_pos !== m_pos) begin
        bad++;
        $display("FAIL retarget @%0d: got sdbarl=%b%b%b%b%b%b pos=%0d want %b%b%b%b%b%b pos=%0d", e_n,
                 step, dir, busy, at_target, tif.tgt_ready, limit_hit, cur_pos, m_step, m_dir, e_busy, e_at, e_rdy, m_lim, m_pos);
      end
      if (cur_pos > maxp) maxp = cur_pos;
      if (step && !prev) rises++;
      prev = step;
      if (!hit && rises == 2 && step) begin
        hit = 1; tif.tgt_valid = 1; tif.tgt_pos = 0;
      end
      if (hit && i > 0 && !m_act && m_pos == m_tgt) begin done = 1; break; end
    end
    total++;
    if (!done || cur_pos !== 0 || maxp !== 2 || rises != 4) begin
      bad++;
      $display("FAIL retarget_end: got done=%0d pos=%0d max=%0d rises=%0d want done=1 pos=0 max=2 rises=4", done, cur_pos, maxp, rises);
    end
  endtask

  task automatic test_enable_drop();
    bit seen = 0, done = 0;
    tif.tgt_valid = 1; tif.tgt_pos = 5; enable = 1;
    for (int i = 0; i < 50; i++) begin
      tick();
      tif.tgt_valid = 0;
      if (step) begin seen = 1; break; end
    end
    enable = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if ({step, dir, busy, at_target, tif.tgt_ready, limit_hit} !== {m_step, m_dir, e_busy, e_at, e_rdy, m_lim} || cur_pos !== m_pos) begin
        bad++;
        $display("FAIL enable_drop @%0d: got sdbarl=%b%b%b%b%b%b pos=%0d want %b%b%b%b%b%b pos=%0d", e_n,
                 step, dir, busy, at_target, tif.tgt_ready, limit_hit, cur_pos, m_step, m_dir, e_busy, e_at, e_rdy, m_lim, m_pos);
      end
    end
    total++;
    if (!seen || cur_pos !== 1 || busy !== 1'b0 || at_target !== 1'b0) begin
      bad++;
      $display("FAIL enable_park: got seen=%0d pos=%0d busy=%b at=%b want seen=1 pos=1 busy=0 at=0", seen, cur_pos, busy, at_target);
    end
    enable = 1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!m_act && m_pos == m_tgt) begin done = 1; break; end
    end
    total++;
    if (!done || cur_pos !== 5 || at_target !== 1'b1) begin
      bad++;
      $display("FAIL enable_resume: got done=%0d pos=%0d at=%b want done=1 pos=5 at=1", done, cur_pos, at_target);
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      enable = ($urandom_range(0, 9) != 0);
      tif.tgt_valid = ($urandom_range(0, 5) == 0);
      r = $urandom_range(0, 16);
      tif.tgt_pos = r - 8;
`ifdef STEP_POS_LIMIT_EN
      if ($urandom_range(0, 49) == 0) begin
        r = $urandom_range(0, 6);
        pos_min = -r;
        r = $urandom_range(0, 8);
        pos_max = r - 2;
      end
`endif
      tick();
      total++;
      if ({step, dir, busy, at_target, tif.tgt_ready, limit_hit} !== {m_step, m_dir, e_busy, e_at, e_rdy, m_lim} || cur_pos !== m_pos) begin
        bad++;
        $display("FAIL random @%0d: got sdbarl=%b%b%b%b%b%b pos=%0d want %b%b%b%b%b%b pos=%0d", e_n,
                 step, dir, busy, at_target, tif.tgt_ready, limit_hit, cur_pos, m_step, m_dir, e_busy, e_at, e_rdy, m_lim, m_pos);
      end
    end
    rst = 0; tif.tgt_valid = 0; enable = 1;
  endtask

`ifdef STEP_POS_LIMIT_EN
  task automatic test_limit();
    bit done = 0;
    rst = 1; tif.tgt_valid = 0;
    tick();
    rst = 0; pos_min = -4; pos_max = 4; enable = 1;
    tif.tgt_valid = 1; tif.tgt_pos = 100;
    tick();
    tif.tgt_valid = 0;
    total++;
    if (limit_hit !== 1'b1) begin
      bad++;
      $display("FAIL limit_set: got %b want 1", limit_hit);
    end
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!m_act && m_pos == m_tgt) begin done = 1; break; end
    end
    total++;
    if (!done || cur_pos !== 4) begin
      bad++;
      $display("FAIL limit_stop: got done=%0d pos=%0d want done=1 pos=4", done, cur_pos);
    end
    tif.tgt_valid = 1; tif.tgt_pos = 2;
    tick();
    tif.tgt_valid = 0;
    total++;
    if (limit_hit !== 1'b0) begin
      bad++;
      $display("FAIL limit_clear: got %b want 0", limit_hit);
    end
    done = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!m_act && m_pos == m_tgt) begin done = 1; break; end
    end
    total++;
    if (!done || cur_pos !== 2 || dir !== 1'b0) begin
      bad++;
      $display("FAIL limit_back: got done=%0d pos=%0d dir=%b want done=1 pos=2 dir=0", done, cur_pos, dir);
    end
  endtask
`endif

  initial begin
    tif.tgt_valid = 0;
    tif.tgt_pos   = 0;
`ifdef STEP_POS_LIMIT_EN
    pos_min = -1000;
    pos_max = 1000;
`endif
    test_reset();
    test_move_up();
    test_reverse();
    test_retarget();
    test_enable_drop();
    test_random();
`ifdef STEP_POS_LIMIT_EN
    test_limit();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
